wilton_cfg_loader: RTL
======================

// Module: wilton_cfg_loader
// PURPOSE
//  Writer side of the Wilton switch configuration interface. Receives a byte-serial config stream
//  with a valid/ready handshake and decodes framed, checksummed records. Drives the
//  port_designations[4] and route[4] inputs of NUM_SW switch instances.
//  The new values for a switch are applied to its outputs atomically, in one cycle.
// PARAMETERS
//  NUM_SW     4      number of switches driven; legal addresses are 0..NUM_SW-1
//  SYNC_BYTE  8'hA5  frame start marker
// PORTS
//  clk                clk    input   1          single clock; every register is on the rising edge
//  reset              reset  input   1          synchronous, active-high
//  in_data            input   8         config stream byte
//  in_valid           input   1         in_data is valid
//  in_ready           output  1         loader accepts a byte this cycle
//  port_designations  output  [NUM_SW][4] x 4   per-switch, per-side port enables
//  route              output  [NUM_SW][4] x 8   per-switch, per-pin mux selects
//  cfg_done           output  1         1-cycle pulse: a record was committed
//  cfg_err            output  1         1-cycle pulse: a record was rejected
//  err_count          output  8         saturating count of rejected records
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Byte transfer: a byte moves only when in_valid && in_ready.
//  Frame format, in order:
//   - SYNC_BYTE
//   - ADDR
//   - P0..P5
//   - CHK
//  Payload mapping:
//   - P0 = {desig[1], desig[0]}, P1 = {desig[3], desig[2]} (low nibble = lower index)
//   - P2..P5 = route[0..3]
//  Checksum: CHK == ADDR ^ P0 ^ P1 ^ P2 ^ P3 ^ P4 ^ P5.
//  FSM states: IDLE, ADDR, PAYLOAD, CHECK, COMMIT.
//  FSM transitions (on each transfer unless stated):
//   - IDLE: a byte == SYNC_BYTE goes to ADDR; any other byte is dropped and the FSM stays in IDLE.
//   - ADDR: latch the address and clear the running XOR to ADDR. Go to PAYLOAD with cnt=0.
//   - PAYLOAD: store the byte into the shadow register at index cnt and XOR it into the sum.
//     After cnt==5 go to CHECK.
//   - CHECK: go to COMMIT if CHK matches the sum and ADDR < NUM_SW; otherwise reject.
//  Reject:
//   - cfg_err pulses in the cycle after the CHK transfer.
//   - err_count increments and saturates at 8'hFF.
//   - No output changes. FSM returns to IDLE.
//  COMMIT (exactly one cycle):
//   - in_ready = 0.
//   - The shadow is copied into port_designations[ADDR] and route[ADDR].
//   - cfg_done = 1. FSM goes to IDLE.
//   - New values are visible on the outputs in the cycle after COMMIT, so 2 cycles after the CHK transfer.
//  in_ready is 1 in every other state.
//  Only the addressed switch changes; all other switches hold their values.
//  An in_valid=0 gap inside a frame simply stalls the FSM; there is no timeout.
//  A SYNC_BYTE value inside ADDR or payload is treated as data, with no resync.
//  Reset values:
//   - all port_designations and route = 0 (all ports disabled, mux select 0)
//   - cfg_done = 0, cfg_err = 0, err_count = 0, in_ready = 1, FSM = IDLE
//  Reset mid-frame: the partial shadow is discarded and committed outputs are cleared to 0.
//   The next frame must start with SYNC_BYTE.
//  Output timing: outputs are registered and change only in COMMIT or reset.
//   The switch registers them again, so total load-to-use latency is 3 cycles after CHK.
// TESTING
//  1. Reset, then a valid frame, then end of frame:
//     - frame: A5,01,21,43,01,02,03,04,67 with no gaps
//     - 2 cycles after CHK: port_designations[1] = {4,3,2,1} for idx 3..0 and route[1] = {04,03,02,01}
//     - cfg_done pulses once; switches 0, 2 and 3 stay at 0
//  2. Same frame with CHK=66:
//     - cfg_err pulses and err_count = 1
//     - no output changes
//  3. ADDR = 07 with a correct CHK (= 07^21^43^01^02^03^04 = 61):
//     - cfg_err pulses
//     - no output changes
//  4. Garbage bytes 00,FF,5A, then frame 1 with in_valid dropped randomly:
//     - garbage bytes are ignored
//     - same result as test 1
//     - in_ready = 0 exactly in the COMMIT cycle
//  5. Assert reset after P3 of a frame:
//     - all outputs = 0
//     - a following complete frame commits correctly
//  6. 300 bad-CHK frames: err_count saturates at FF.

Source files
------------

// File: rtl/wilton_cfg_loader_if.sv
// wilton_cfg_loader_if: byte-serial config stream with valid/ready handshake
//   in_data  : config stream byte
//   in_valid : in_data is valid
//   in_ready : loader accepts a byte this cycle
interface wilton_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/wilton_cfg_loader.sv
// wilton_cfg_loader: decodes framed, checksummed config records and commits them atomically to one switch
//   clk, reset        : single clock, synchronous active-high reset
//   stream            : byte stream (slave side of wilton_cfg_loader_if)
//   port_designations : per-switch, per-side 4-bit port enables
//   route             : per-switch, per-pin 8-bit mux selects
//   cfg_done          : 1-cycle pulse when a record is committed
//   cfg_err           : 1-cycle pulse when a record is rejected
//   err_count         : saturating count of rejected records
module wilton_cfg_loader #(
  parameter int         NUM_SW    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                           clk,
  input  logic                           reset,
  wilton_cfg_loader_if.slave             stream,
  output logic [NUM_SW-1:0][3:0][3:0]    port_designations,
  output logic [NUM_SW-1:0][3:0][7:0]    route,
  output logic                           cfg_done,
  output logic                           cfg_err,
  output logic [7:0]                     err_count
);
  localparam int AW = NUM_SW > 1 ? $clog2(NUM_SW) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, PAYLOAD, CHECK, COMMIT} state_t;
  state_t state, state_nx;
  logic [7:0] addr, sum;
  logic [2:0] cnt;
  logic [5:0][7:0] shadow;
  logic xfer, ok, reject;
  assign stream.in_ready = state != COMMIT;
  assign xfer = stream.in_valid && stream.in_ready;
  assign ok = stream.in_data == sum && int'(addr) < NUM_SW;
  assign reject = xfer && state == CHECK && !ok;
  assign cfg_done = state == COMMIT;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == COMMIT) state_nx = IDLE;
    else if (xfer)
      case (state)
        IDLE:    state_nx = stream.in_data == SYNC_BYTE ? ADDR : IDLE;
        ADDR:    state_nx = PAYLOAD;
        PAYLOAD: state_nx = cnt == 3'd5 ? CHECK : PAYLOAD;
        CHECK:   state_nx = ok ? COMMIT : IDLE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      addr              <= '0;
      sum               <= '0;
      cnt               <= '0;
      shadow            <= '0;
      port_designations <= '0;
      route             <= '0;
      cfg_err           <= 1'b0;
      err_count         <= '0;
    end else begin
      cfg_err <= reject;
      if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (xfer && state == ADDR) begin
        addr <= stream.in_data;
        sum  <= stream.in_data;
        cnt  <= '0;
      end
      if (xfer && state == PAYLOAD) begin
        shadow[cnt] <= stream.in_data;
        sum         <= sum ^ stream.in_data;
        cnt         <= cnt + 3'd1;
      end
      // P1:P0 pack desig[3..0] and P5..P2 pack route[3..0], so whole-slice copies suffice
      if (state == COMMIT) begin
        port_designations[addr[AW-1:0]] <= {shadow[1], shadow[0]};
        route[addr[AW-1:0]]             <= shadow[5:2];
      end
    end
endmodule
